// File: rtl/cp0_tlb_pkg.sv
// Shared CP0 definitions: register addresses {rd, sel} and exception codes.
// Also holds small helpers that classify exception codes.
package cp0_tlb_pkg;

    localparam logic [7:0] CP0_INDEX    = 8'h00;
    localparam logic [7:0] CP0_ENTRYLO0 = 8'h10;
    localparam logic [7:0] CP0_ENTRYLO1 = 8'h18;
    localparam logic [7:0] CP0_BADVADDR = 8'h40;
    localparam logic [7:0] CP0_COUNT    = 8'h48;
    localparam logic [7:0] CP0_ENTRYHI  = 8'h50;
    localparam logic [7:0] CP0_COMPARE  = 8'h58;
    localparam logic [7:0] CP0_STATUS   = 8'h60;
    localparam logic [7:0] CP0_CAUSE    = 8'h68;
    localparam logic [7:0] CP0_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Exceptions that report the faulting address in BadVAddr.
    function automatic logic exc_has_badvaddr(input logic [4:0] code);
        return code inside {EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES};
    endfunction

    // TLB exceptions also latch the faulting VPN2 into EntryHi.
    function automatic logic exc_is_tlb(input logic [4:0] code);
        return code inside {EXC_MOD, EXC_TLBL, EXC_TLBS};
    endfunction

endpackage

// File: rtl/cp0_tlb_timer.sv
// CP0 Count/Compare timer with a Count prescaler.
// TI is sticky until software rewrites Compare.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti,
    output logic        count_eq_compare
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc;

    assign count_eq_compare = (count == compare);

    // Prescaler and Count; a software load restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
        end else if (count_we) begin
            presc <= '0;
            count <= wdata;
        end else if (presc == PMAX) begin
            presc <= '0;
            count <= count + 32'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Compare register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare <= '0;
        end else if (compare_we) begin
            compare <= wdata;
        end
    end

    // Timer interrupt flag; a Compare write clears it over a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ti <= 1'b0;
        end else if (compare_we) begin
            ti <= 1'b0;
        end else if (count_eq_compare) begin
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_tlb.sv
// CP0 register file beside WB: exceptions, interrupts, timer and TLB regs.
// A committing exception blocks every software or TLB-op write that cycle.
module cp0_tlb
    import cp0_tlb_pkg::*;
#(
    parameter int TLBNUM      = 16,
    parameter int EXT_INT_NUM = 6,
    parameter int COUNT_DIV   = 2,
    localparam int IDX_W      = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mtc0_we,
    input  logic [7:0]             cp0_addr,
    input  logic [31:0]            cp0_wdata,
    output logic [31:0]            cp0_rdata,
    input  logic                   eret_flush,
    input  logic                   wb_ex,
    input  logic [4:0]             wb_exccode,
    input  logic                   wb_bd,
    input  logic [31:0]            wb_pc,
    input  logic [31:0]            wb_badvaddr,
    input  logic [EXT_INT_NUM-1:0] ext_int_in,
    input  logic                   tlbp_we,
    input  logic                   tlbp_found,
    input  logic [IDX_W-1:0]       tlbp_index,
    input  logic                   tlbr_we,
    input  logic [31:0]            tlbr_entryhi,
    input  logic [31:0]            tlbr_entrylo0,
    input  logic [31:0]            tlbr_entrylo1,
    output logic [31:0]            cp0_index,
    output logic [31:0]            cp0_entryhi,
    output logic [31:0]            cp0_entrylo0,
    output logic [31:0]            cp0_entrylo1,
    output logic [31:0]            cp0_epc,
    output logic                   has_int
);

    logic             idx_p;
    logic [IDX_W-1:0] idx_val;
    logic [18:0]      hi_vpn2;
    logic [7:0]       hi_asid;
    logic [25:0]      lo0;
    logic [25:0]      lo1;
    logic [7:0]       st_im;
    logic             st_exl;
    logic             st_ie;
    logic             ca_bd;
    logic [1:0]       ip_sw;
    logic [5:0]       ip_hw;
    logic [4:0]       ca_exc;
    logic [31:0]      epc;
    logic [31:0]      badvaddr;
    logic [31:0]      count;
    logic [31:0]      compare;
    logic             ti;
    logic             timer_eq;
    logic [5:0]       ext_pad;
    logic [5:0]       ip_hw_d;
    logic [7:0]       ip;

    logic wr;
    logic wr_index, wr_entryhi, wr_lo0, wr_lo1;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr         = mtc0_we & ~wb_ex;
    assign wr_index   = wr & (cp0_addr == CP0_INDEX);
    assign wr_entryhi = wr & (cp0_addr == CP0_ENTRYHI);
    assign wr_lo0     = wr & (cp0_addr == CP0_ENTRYLO0);
    assign wr_lo1     = wr & (cp0_addr == CP0_ENTRYLO1);
    assign wr_count   = wr & (cp0_addr == CP0_COUNT);
    assign wr_compare = wr & (cp0_addr == CP0_COMPARE);
    assign wr_status  = wr & (cp0_addr == CP0_STATUS);
    assign wr_cause   = wr & (cp0_addr == CP0_CAUSE);
    assign wr_epc     = wr & (cp0_addr == CP0_EPC);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk              (clk),
        .rst              (rst),
        .count_we         (wr_count),
        .compare_we       (wr_compare),
        .wdata            (cp0_wdata),
        .count            (count),
        .compare          (compare),
        .ti               (ti),
        .count_eq_compare (timer_eq)
    );

    // Missing interrupt lines zero-extend so unused IP bits read 0.
    assign ext_pad = 6'(ext_int_in);
    assign ip_hw_d = {ti | ext_pad[5], ext_pad[4:0]};
    assign ip      = {ip_hw, ip_sw};

    // Hardware interrupt pending bits IP[7:2], sampled every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_hw <= '0;
        end else begin
            ip_hw <= ip_hw_d;
        end
    end

    // Status, Cause, EPC and BadVAddr: exception entry, ERET and MTC0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_im    <= '0;
            st_exl   <= 1'b0;
            st_ie    <= 1'b0;
            ca_bd    <= 1'b0;
            ip_sw    <= '0;
            ca_exc   <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else if (wb_ex) begin
            st_exl <= 1'b1;
            ca_exc <= wb_exccode;
            if (!st_exl) begin
                ca_bd <= wb_bd;
                epc   <= wb_bd ? wb_pc - 32'd4 : wb_pc;
            end
            if (exc_has_badvaddr(wb_exccode)) begin
                badvaddr <= wb_badvaddr;
            end
        end else begin
            if (eret_flush) begin
                st_exl <= 1'b0;
            end else if (wr_status) begin
                st_exl <= cp0_wdata[1];
            end
            if (wr_status) begin
                st_im <= cp0_wdata[15:8];
                st_ie <= cp0_wdata[0];
            end
            if (wr_cause) begin
                ip_sw <= cp0_wdata[9:8];
            end
            if (wr_epc) begin
                epc <= cp0_wdata;
            end
        end
    end

    // TLB management registers: exception VPN2 capture, TLBP, TLBR, MTC0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_p   <= 1'b0;
            idx_val <= '0;
            hi_vpn2 <= '0;
            hi_asid <= '0;
            lo0     <= '0;
            lo1     <= '0;
        end else if (wb_ex) begin
            if (exc_is_tlb(wb_exccode)) begin
                hi_vpn2 <= wb_badvaddr[31:13];
            end
        end else if (tlbp_we) begin
            idx_p <= ~tlbp_found;
            if (tlbp_found) begin
                idx_val <= tlbp_index;
            end
        end else if (tlbr_we) begin
            hi_vpn2 <= tlbr_entryhi[31:13];
            hi_asid <= tlbr_entryhi[7:0];
            lo0     <= tlbr_entrylo0[25:0];
            lo1     <= tlbr_entrylo1[25:0];
        end else begin
            if (wr_index) begin
                idx_p   <= cp0_wdata[31];
                idx_val <= cp0_wdata[IDX_W-1:0];
            end
            if (wr_entryhi) begin
                hi_vpn2 <= cp0_wdata[31:13];
                hi_asid <= cp0_wdata[7:0];
            end
            if (wr_lo0) begin
                lo0 <= cp0_wdata[25:0];
            end
            if (wr_lo1) begin
                lo1 <= cp0_wdata[25:0];
            end
        end
    end

    // Assemble the Index word; bits between P and the index field read 0.
    always_comb begin
        cp0_index              = '0;
        cp0_index[31]          = idx_p;
        cp0_index[IDX_W-1:0]   = idx_val;
    end

    assign cp0_entryhi  = {hi_vpn2, 5'b0, hi_asid};
    assign cp0_entrylo0 = {6'b0, lo0};
    assign cp0_entrylo1 = {6'b0, lo1};
    assign cp0_epc      = epc;

    assign has_int = (|(ip & st_im)) & st_ie & ~st_exl;

    // MFC0 read mux; unmapped addresses read 0.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_INDEX:    cp0_rdata = cp0_index;
            CP0_ENTRYLO0: cp0_rdata = cp0_entrylo0;
            CP0_ENTRYLO1: cp0_rdata = cp0_entrylo1;
            CP0_BADVADDR: cp0_rdata = badvaddr;
            CP0_COUNT:    cp0_rdata = count;
            CP0_ENTRYHI:  cp0_rdata = cp0_entryhi;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS: begin
                cp0_rdata[22]   = 1'b1;
                cp0_rdata[15:8] = st_im;
                cp0_rdata[1]    = st_exl;
                cp0_rdata[0]    = st_ie;
            end
            CP0_CAUSE: begin
                cp0_rdata[31]   = ca_bd;
                cp0_rdata[30]   = ti;
                cp0_rdata[15:8] = ip;
                cp0_rdata[6:2]  = ca_exc;
            end
            CP0_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = '0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{timer_eq, tlbr_entryhi[12:8],
                         tlbr_entrylo0[31:26], tlbr_entrylo1[31:26]};

endmodule

// File: tb/tb_cp0_tlb.sv
// Testbench for cp0_tlb: directed scenarios plus random traffic.
// A register-level model predicts every CP0 read and output.
module tb_cp0_tlb;
    import cp0_tlb_pkg::*;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;
    localparam int EXT    = 6;
    localparam int DIV    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mtc0_we;
    logic [7:0]       cp0_addr;
    logic [31:0]      cp0_wdata;
    logic [31:0]      cp0_rdata;
    logic             eret_flush;
    logic             wb_ex;
    logic [4:0]       wb_exccode;
    logic             wb_bd;
    logic [31:0]      wb_pc;
    logic [31:0]      wb_badvaddr;
    logic [EXT-1:0]   ext_int_in;
    logic             tlbp_we;
    logic             tlbp_found;
    logic [IDX_W-1:0] tlbp_index;
    logic             tlbr_we;
    logic [31:0]      tlbr_entryhi;
    logic [31:0]      tlbr_entrylo0;
    logic [31:0]      tlbr_entrylo1;
    logic [31:0]      cp0_index;
    logic [31:0]      cp0_entryhi;
    logic [31:0]      cp0_entrylo0;
    logic [31:0]      cp0_entrylo1;
    logic [31:0]      cp0_epc;
    logic             has_int;

    cp0_tlb #(
        .TLBNUM      (TLBNUM),
        .EXT_INT_NUM (EXT),
        .COUNT_DIV   (DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mtc0_we       (mtc0_we),
        .cp0_addr      (cp0_addr),
        .cp0_wdata     (cp0_wdata),
        .cp0_rdata     (cp0_rdata),
        .eret_flush    (eret_flush),
        .wb_ex         (wb_ex),
        .wb_exccode    (wb_exccode),
        .wb_bd         (wb_bd),
        .wb_pc         (wb_pc),
        .wb_badvaddr   (wb_badvaddr),
        .ext_int_in    (ext_int_in),
        .tlbp_we       (tlbp_we),
        .tlbp_found    (tlbp_found),
        .tlbp_index    (tlbp_index),
        .tlbr_we       (tlbr_we),
        .tlbr_entryhi  (tlbr_entryhi),
        .tlbr_entrylo0 (tlbr_entrylo0),
        .tlbr_entrylo1 (tlbr_entrylo1),
        .cp0_index     (cp0_index),
        .cp0_entryhi   (cp0_entryhi),
        .cp0_entrylo0  (cp0_entrylo0),
        .cp0_entrylo1  (cp0_entrylo1),
        .cp0_epc       (cp0_epc),
        .has_int       (has_int)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Architectural register model
    logic             m_p;
    logic [IDX_W-1:0] m_idx;
    logic [18:0]      m_vpn2;
    logic [7:0]       m_asid;
    logic [25:0]      m_lo0, m_lo1;
    logic [7:0]       m_im;
    logic             m_exl, m_ie, m_bd, m_ti;
    logic [7:0]       m_ip;
    logic [4:0]       m_exc;
    logic [31:0]      m_epc, m_bad, m_base, m_cmp;
    longint           m_cyc;

    task automatic model_reset();
        m_p = 0; m_idx = '0; m_vpn2 = '0; m_asid = '0;
        m_lo0 = '0; m_lo1 = '0; m_im = '0; m_exl = 0; m_ie = 0;
        m_bd = 0; m_ti = 0; m_ip = '0; m_exc = '0;
        m_epc = '0; m_bad = '0; m_base = '0; m_cmp = '0; m_cyc = 0;
    endtask

    // Count = value last loaded + whole prescaler periods elapsed since.
    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / DIV);
    endfunction

    function automatic logic m_has_int();
        return (|(m_ip & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            CP0_INDEX:    begin r[31] = m_p; r[IDX_W-1:0] = m_idx; end
            CP0_ENTRYLO0: r = {6'b0, m_lo0};
            CP0_ENTRYLO1: r = {6'b0, m_lo1};
            CP0_BADVADDR: r = m_bad;
            CP0_COUNT:    r = m_count();
            CP0_ENTRYHI:  r = {m_vpn2, 5'b0, m_asid};
            CP0_COMPARE:  r = m_cmp;
            CP0_STATUS:   begin
                r[22] = 1'b1; r[15:8] = m_im; r[1] = m_exl; r[0] = m_ie;
            end
            CP0_CAUSE:    begin
                r[31] = m_bd; r[30] = m_ti; r[15:8] = m_ip; r[6:2] = m_exc;
            end
            CP0_EPC:      r = m_epc;
            default:      r = '0;
        endcase
        return r;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic [31:0] cnt;
        logic        eq, ti_old, wr;
        logic [5:0]  ext;
        cnt    = m_count();
        eq     = (cnt == m_cmp);
        ti_old = m_ti;
        wr     = mtc0_we && !wb_ex;
        ext    = 6'(ext_int_in);
        if (wr && cp0_addr == CP0_COUNT) begin
            m_base = cp0_wdata; m_cyc = 0;
        end else begin
            m_cyc++;
        end
        if (wr && cp0_addr == CP0_COMPARE) begin
            m_cmp = cp0_wdata; m_ti = 0;
        end else if (eq) begin
            m_ti = 1;
        end
        m_ip[7:2] = '0;
        for (int k = 0; k < EXT; k++) m_ip[2+k] = ext[k];
        m_ip[7] = m_ip[7] | ti_old;
        if (wb_ex) begin
            if (!m_exl) begin
                m_bd  = wb_bd;
                m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
            end
            m_exl = 1;
            m_exc = wb_exccode;
            if (wb_exccode >= 1 && wb_exccode <= 5) m_bad = wb_badvaddr;
            if (wb_exccode >= 1 && wb_exccode <= 3) m_vpn2 = wb_badvaddr[31:13];
        end else begin
            if (mtc0_we) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        m_im = cp0_wdata[15:8];
                        m_ie = cp0_wdata[0];
                        if (!eret_flush) m_exl = cp0_wdata[1];
                    end
                    CP0_CAUSE:    m_ip[1:0] = cp0_wdata[9:8];
                    CP0_EPC:      m_epc = cp0_wdata;
                    CP0_INDEX:    begin
                        m_p = cp0_wdata[31]; m_idx = cp0_wdata[IDX_W-1:0];
                    end
                    CP0_ENTRYHI:  begin
                        m_vpn2 = cp0_wdata[31:13]; m_asid = cp0_wdata[7:0];
                    end
                    CP0_ENTRYLO0: m_lo0 = cp0_wdata[25:0];
                    CP0_ENTRYLO1: m_lo1 = cp0_wdata[25:0];
                    default: ;
                endcase
            end
            if (eret_flush) m_exl = 0;
            if (tlbp_we) begin
                if (tlbp_found) begin
                    m_p = 0; m_idx = tlbp_index;
                end else begin
                    m_p = 1;
                end
            end
            if (tlbr_we) begin
                m_vpn2 = tlbr_entryhi[31:13];
                m_asid = tlbr_entryhi[7:0];
                m_lo0  = tlbr_entrylo0[25:0];
                m_lo1  = tlbr_entrylo1[25:0];
            end
        end
    endtask

    task automatic clear_strobes();
        mtc0_we = 0; wb_ex = 0; eret_flush = 0; tlbp_we = 0; tlbr_we = 0;
    endtask

    // One clock: compare outputs with the model, then cross the edge.
    task automatic step();
        @(negedge clk);
        check_eq($sformatf("rdata@%02h", cp0_addr), cp0_rdata,
                 model_read(cp0_addr));
        check_eq("index", cp0_index, model_read(CP0_INDEX));
        check_eq("entryhi", cp0_entryhi, model_read(CP0_ENTRYHI));
        check_eq("entrylo0", cp0_entrylo0, model_read(CP0_ENTRYLO0));
        check_eq("entrylo1", cp0_entrylo1, model_read(CP0_ENTRYLO1));
        check_eq("epc", cp0_epc, m_epc);
        check_eq("has_int", 32'(has_int), 32'(m_has_int()));
        model_edge();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rd_eq(input string tag, input logic [7:0] a,
                         input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check_eq(tag, cp0_rdata, exp);
    endtask

    logic [7:0] addrs [12];
    logic [4:0] codes [10];

    initial begin
        addrs = '{CP0_INDEX, CP0_ENTRYLO0, CP0_ENTRYLO1, CP0_BADVADDR,
                  CP0_COUNT, CP0_ENTRYHI, CP0_COMPARE, CP0_STATUS,
                  CP0_CAUSE, CP0_EPC, 8'h08, 8'h61};
        codes = '{EXC_INT, EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL,
                  EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
        rst = 1;
        clear_strobes();
        cp0_addr = '0; cp0_wdata = '0; wb_exccode = '0; wb_bd = 0;
        wb_pc = '0; wb_badvaddr = '0; ext_int_in = '0;
        tlbp_found = 0; tlbp_index = '0;
        tlbr_entryhi = '0; tlbr_entrylo0 = '0; tlbr_entrylo1 = '0;
        #2;
        foreach (addrs[i]) begin
            rd_eq($sformatf("reset_rd@%02h", addrs[i]), addrs[i],
                  (addrs[i] == CP0_STATUS) ? 32'h0040_0000 : 32'h0);
        end
        check_eq("reset_has_int", 32'(has_int), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;

        // Count with prescaler, Compare match, TI and IP7
        mtc0(CP0_COUNT, 32'h0);
        idle(10);
        rd_eq("count_after_10", CP0_COUNT, 32'd5);
        mtc0(CP0_COMPARE, 32'd5);
        cp0_addr = CP0_CAUSE; #1;
        check_eq("ti_cleared", 32'(cp0_rdata[30]), 32'h0);
        step();
        cp0_addr = CP0_CAUSE; #1;
        check_eq("ti_set", 32'(cp0_rdata[30]), 32'h1);
        step();
        cp0_addr = CP0_CAUSE; #1;
        check_eq("ip7_set", 32'(cp0_rdata[15]), 32'h1);
        mtc0(CP0_STATUS, 32'h0000_8001);
        check_eq("timer_has_int", 32'(has_int), 32'h1);
        mtc0(CP0_COMPARE, 32'h0000_1000);
        cp0_addr = CP0_CAUSE; #1;
        check_eq("ti_rewrite_clr", 32'(cp0_rdata[30]), 32'h0);
        mtc0(CP0_STATUS, 32'h0);

        // TLB refill exception in a delay slot, then a nested one
        mtc0(CP0_ENTRYHI, 32'h0000_00A5);
        wb_ex = 1; wb_exccode = EXC_TLBL; wb_bd = 1;
        wb_pc = 32'hBFC0_0104; wb_badvaddr = 32'h1234_5678;
        step();
        check_eq("tlbl_epc", cp0_epc, 32'hBFC0_0100);
        rd_eq("tlbl_badvaddr", CP0_BADVADDR, 32'h1234_5678);
        cp0_addr = CP0_CAUSE; #1;
        check_eq("tlbl_bd", 32'(cp0_rdata[31]), 32'h1);
        check_eq("tlbl_entryhi", cp0_entryhi, 32'h1234_40A5);
        wb_ex = 1; wb_exccode = EXC_ADEL; wb_bd = 0;
        wb_pc = 32'h8000_0000; wb_badvaddr = 32'hDEAD_BEEF;
        step();
        check_eq("nested_epc", cp0_epc, 32'hBFC0_0100);
        rd_eq("adel_badvaddr", CP0_BADVADDR, 32'hDEAD_BEEF);
        check_eq("adel_entryhi", cp0_entryhi, 32'h1234_40A5);
        eret_flush = 1;
        step();

        // TLBP hit then miss
        tlbp_we = 1; tlbp_found = 1; tlbp_index = 4'd7;
        step();
        check_eq("tlbp_hit", cp0_index, 32'h0000_0007);
        tlbp_we = 1; tlbp_found = 0; tlbp_index = 4'd3;
        step();
        check_eq("tlbp_miss", cp0_index, 32'h8000_0007);

        // TLBR blocked by an exception, then allowed
        wb_ex = 1; wb_exccode = EXC_SYS; wb_bd = 0; wb_pc = 32'h0000_0100;
        tlbr_we = 1; tlbr_entryhi = '1; tlbr_entrylo0 = '1; tlbr_entrylo1 = '1;
        step();
        check_eq("tlbr_blk_hi", cp0_entryhi, 32'h1234_40A5);
        check_eq("tlbr_blk_lo0", cp0_entrylo0, 32'h0);
        eret_flush = 1;
        step();
        tlbr_we = 1;
        step();
        check_eq("tlbr_hi", cp0_entryhi, 32'hFFFF_E0FF);
        check_eq("tlbr_lo0", cp0_entrylo0, 32'h03FF_FFFF);
        check_eq("tlbr_lo1", cp0_entrylo1, 32'h03FF_FFFF);

        // ERET beats an MTC0 setting EXL; external interrupt latency
        eret_flush = 1;
        mtc0(CP0_STATUS, 32'h0000_0403);
        rd_eq("eret_status", CP0_STATUS, 32'h0040_0401);
        ext_int_in = 6'b000001;
        #1;
        check_eq("ext_int_pre", 32'(has_int), 32'h0);
        step();
        check_eq("ext_int_post", 32'(has_int), 32'h1);
        ext_int_in = '0;
        step();

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            int r, sel;
            r   = $urandom_range(0, 15);
            sel = $urandom_range(0, 5);
            cp0_addr    = addrs[$urandom_range(0, 11)];
            cp0_wdata   = $urandom;
            ext_int_in  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : '0;
            wb_ex       = (r == 0);
            eret_flush  = (r == 1);
            wb_exccode  = codes[$urandom_range(0, 9)];
            wb_bd       = 1'($urandom);
            wb_pc       = $urandom;
            wb_badvaddr = $urandom;
            mtc0_we     = (sel < 3);
            tlbp_we     = (sel == 3);
            tlbr_we     = (sel == 4);
            tlbp_found  = 1'($urandom);
            tlbp_index  = 4'($urandom);
            tlbr_entryhi  = $urandom;
            tlbr_entrylo0 = $urandom;
            tlbr_entrylo1 = $urandom;
            if (cp0_addr == CP0_COMPARE && $urandom_range(0, 1) == 1)
                cp0_wdata = m_count() + 32'($urandom_range(0, 3));
            if (cp0_addr == CP0_STATUS && $urandom_range(0, 1) == 1)
                cp0_wdata[1] = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_tlb.md
Name: cp0_tlb

Overview:
Parametrised next-generation CP0 register file for the MIPS pipeline, instantiated beside the WB stage. It adds the TLB-management registers Index, EntryHi, EntryLo0 and EntryLo1, with TLBP/TLBR update paths and TLB-exception side effects. It also adds a configurable external-interrupt count and a configurable Count prescaler. It keeps the Status/Cause/EPC/BadVAddr/Count/Compare semantics and drives has_int to the pipeline.

Parameters:
TLBNUM, 16, number of TLB entries; IDX_W = clog2(TLBNUM).
EXT_INT_NUM, 6, external interrupt lines, 1..6; they map to IP2 upward, and unused IP bits read 0.
COUNT_DIV, 2, Count increments once every COUNT_DIV cycles; must be 1 or more.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mtc0_we  in  1  MTC0 write strobe
cp0_addr  in  8  {rd[4:0], sel[2:0]}
cp0_wdata  in  32  MTC0 data
cp0_rdata  out  32  MFC0 read data (combinational)
eret_flush  in  1  ERET commits
wb_ex  in  1  exception commits
wb_exccode  in  5  exception code
wb_bd  in  1  excepting instruction is in a delay slot
wb_pc  in  32  excepting PC
wb_badvaddr  in  32  faulting address
ext_int_in  in  EXT_INT_NUM  level interrupts
tlbp_we  in  1  TLBP commits
tlbp_found  in  1  TLBP hit
tlbp_index  in  IDX_W  TLBP hit index
tlbr_we  in  1  TLBR commits
tlbr_entryhi  in  32  EntryHi read from the TLB
tlbr_entrylo0  in  32  EntryLo0 read from the TLB
tlbr_entrylo1  in  32  EntryLo1 read from the TLB
cp0_index  out  32  Index register, to the TLB
cp0_entryhi  out  32  EntryHi register
cp0_entrylo0  out  32  EntryLo0 register
cp0_entrylo1  out  32  EntryLo1 register
cp0_epc  out  32  EPC, to the ERET target
has_int  out  1  interrupt pending

Behaviour:
- Writable fields are listed below; all other bits read 0.
  - Index: P[31], index[IDX_W-1:0].
  - EntryHi: VPN2[31:13], ASID[7:0].
  - EntryLo0/1: [25:0].
  - Status: BEV[22] hard-wired 1, IM[15:8], EXL[1], IE[0].
  - Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2].
- Reset (asynchronous):
  - Every register bit clears to 0, including the prescaler, EPC, BadVAddr, Count and Compare.
  - BEV remains 1.
  - Resulting outputs: has_int=0 and cp0_rdata=0 for every non-Status address; reading Status returns 0x0040_0000.
- All updates take effect on the rising clk edge.
- wb_ex has top priority: in a wb_ex cycle, mtc0/tlbp/tlbr writes are ignored. The pipeline guarantees that at most one of mtc0_we, tlbp_we and tlbr_we is asserted.
- On wb_ex:
  - EXL<=1 and ExcCode<=wb_exccode.
  - If EXL was 0: BD<=wb_bd and EPC<=wb_bd ? wb_pc-4 : wb_pc.
  - For codes 1, 2, 3, 4, 5 (Mod, TLBL, TLBS, AdEL, AdES): BadVAddr<=wb_badvaddr.
  - For codes 1, 2, 3 only: EntryHi.VPN2<=wb_badvaddr[31:13]; ASID is unchanged.
- eret_flush (without wb_ex): EXL<=0. It takes priority over an MTC0 write to Status.EXL.
- MTC0 writes only the writable fields. IP[1:0] are written through Cause; IP[7:2] are read-only.
- tlbp_we:
  - Hit: P<=0 and index<=tlbp_index.
  - Miss: P<=1 and the index field is unchanged.
- tlbr_we: EntryHi, EntryLo0 and EntryLo1 load their writable fields from the tlbr_* inputs.
- Count:
  - The prescaler counts from 0 to COUNT_DIV-1 and wraps; Count increments (mod 2^32) on the wrap cycle.
  - An MTC0 to Count loads Count and zeroes the prescaler, and wins over the increment in the same cycle.
- TI:
  - Set on any cycle where Count==Compare.
  - An MTC0 to Compare clears TI and wins over a same-cycle set.
- IP registration: IP[7]<=TI | (EXT_INT_NUM==6 ? ext_int_in[5] : 0); IP[2+k]<=ext_int_in[k]. These are registered each cycle, giving one cycle of latency from input to has_int.
- has_int = |(IP & IM) & IE & ~EXL.
- MFC0 read is combinational on cp0_addr. An unmapped address reads 0.

Decomposition:
- Shared package (mycpu.h): address constants.
  - INDEX 8'h00, ENTRYLO0 8'h10, ENTRYLO1 8'h18, BADVADDR 8'h40, COUNT 8'h48.
  - ENTRYHI 8'h50, COMPARE 8'h58, STATUS 8'h60, CAUSE 8'h68, EPC 8'h70.
  - ExcCode constants INT 0, MOD 1, TLBL 2, TLBS 3, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12.
- One sub-module, cp0_timer: prescaler, Count, Compare, TI and count_eq_compare.

Test Plan:
- Reset, then read all addresses → Status=0x0040_0000, all others 0; has_int=0.
- COUNT_DIV=2: write Count=0, wait 10 cycles → Count=5. Write Compare=5 → TI=1 when equal, IP7 set one cycle later. With IM7=1 and IE=1 → has_int=1. Write Compare → TI=0.
- wb_ex with code 2 (TLBL), badvaddr 0x1234_5678, bd=1, pc 0xBFC0_0104, EXL=0 → EPC=0xBFC0_0100, BD=1, BadVAddr=0x1234_5678, EntryHi[31:13]=0x091A2, ASID kept. A second wb_ex with EXL=1 leaves EPC unchanged.
- tlbp hit with index 7 → Index=0x0000_0007. Then a tlbp miss → Index=0x8000_0007.
- tlbr with entryhi=0xFFFF_FFFF → EntryHi=0xFFFF_E0FF; entrylo0=0xFFFF_FFFF → EntryLo0=0x03FF_FFFF. A same-cycle wb_ex blocks both loads.
- eret_flush and an MTC0 Status with EXL=1 in the same cycle → EXL=0. ext_int_in[0]=1 with IM2=1, IE=1 → has_int asserts one cycle later.
